rf_wb_scheduler: RTL and testbench
==================================

// Module: rf_wb_scheduler
// PURPOSE
//  Owns the single register-file write port and its write-data mux select (PC / CSR / DOUT2 / ALU_RESULT).
//  Two requesters compete for the port:
//   - core retire path: PC link, CSR read, or ALU result;
//   - memory load-return path: DOUT2.
//  Arbitrates between them, bounds core starvation, tracks outstanding loads, and drives registered
//  rf_wr_sel / rf_wr_en / rf_wa to the write mux and register file.
// PARAMETERS
//  MAX_DEFER        4                             consecutive core losses before core gets forced priority (>=1)
//  MAX_OUTSTANDING  2                             max issued-but-unreturned loads (>=1)
//  CNT_W            $clog2(MAX_OUTSTANDING+1)     width of outstanding-load counter
// PORTS
//  CLK             in   1      clock, rising edge
//  RST_N           in   1      reset, asynchronous, active-low
//  core_wb_valid   in   1      core write-back request
//  core_wb_sel     in   2      00=PC, 01=CSR, 11=ALU; 10 illegal on this port
//  core_wb_rd      in   5      core destination register
//  core_wb_ready   out  1      core request granted this cycle (combinational)
//  mem_wb_valid    in   1      load data return request
//  mem_wb_rd       in   5      load destination register
//  mem_wb_ready    out  1      load return granted this cycle (combinational)
//  ld_issue        in   1      load issued to memory this cycle
//  ld_issue_ok     out  1      ld_outstanding < MAX_OUTSTANDING (combinational)
//  flush           in   1      pipeline flush: kills this cycle's core request, resets fairness
//  rf_wr_sel       out  2      write-data mux select (registered)
//  rf_wr_en        out  1      register-file write enable (registered)
//  rf_wa           out  5      register-file write address (registered)
//  ld_outstanding  out  CNT_W  loads in flight (registered)
//  wb_err          out  1      one-cycle pulse on protocol error (registered)
// BEHAVIOUR
//  Reset (RST_N=0, async): rf_wr_sel=00, rf_wr_en=0, rf_wa=0, ld_outstanding=0, wb_err=0, state=PRIO_MEM, defer_cnt=0.
//  Eligibility:
//   - core_elig = core_wb_valid & ~flush & (core_wb_sel != 10).
//   - mem_elig  = mem_wb_valid; flush does not affect the mem path.
//  Illegal core request (core_wb_valid & ~flush & sel==10):
//   - core_wb_ready=1 (consumed), no write issued, wb_err=1 next cycle.
//   - Does not count as a port grant; mem may still be granted the same cycle.
//  FSM states:
//   - PRIO_MEM: if mem_elig, grant mem; else if core_elig, grant core.
//   - PRIO_CORE: if core_elig, grant core; else if mem_elig, grant mem.
//  At most one of {mem grant, legal core grant} per cycle. ready = grant for the respective requester.
//  Starvation counter (defer_cnt, 0..MAX_DEFER-1):
//   - In PRIO_MEM, core_elig & mem granted -> defer_cnt++.
//   - If defer_cnt == MAX_DEFER-1 at that event -> go to PRIO_CORE, defer_cnt=0.
//   - In PRIO_MEM, core granted -> defer_cnt=0.
//   - Cycle with no core_elig and no flush -> defer_cnt holds.
//  PRIO_CORE -> PRIO_MEM on the first core grant; remains PRIO_CORE while core_elig=0.
//  flush=1 -> next state PRIO_MEM, defer_cnt=0. Overrides all other transitions.
//  Write output, latency 1:
//   - A grant in cycle N drives rf_wr_sel / rf_wa in cycle N+1.
//   - Mem grant: sel=10. Core grant: sel=core_wb_sel.
//   - rf_wr_en = granted & (rd != 0); x0 writes are consumed but suppressed.
//   - No grant: rf_wr_en=0; sel and wa hold their previous values.
//  Outstanding-load counter:
//   - +1 on ld_issue & ld_issue_ok; -1 on mem grant; both in the same cycle -> unchanged.
//   - ld_issue while ~ld_issue_ok -> ignored, wb_err=1.
//   - Mem grant while ld_outstanding==0 -> counter stays 0, write still performed, wb_err=1.
//  wb_err is the OR of all error events in the cycle, registered; it is high for exactly one cycle per erroring cycle.
//  Reset asserted mid-operation: outputs clear immediately; an in-flight write is dropped.
// TESTING
//  1. Reset, core_wb_valid with sel=11, rd=5 -> core_wb_ready=1 same cycle; next cycle rf_wr_en=1, rf_wr_sel=11, rf_wa=5.
//  2. ld_issue x2 -> ld_outstanding=2, ld_issue_ok=0; third ld_issue -> ignored, wb_err pulse, count stays 2.
//  3. mem and core both valid continuously, MAX_DEFER=4 -> mem granted 4 cycles, core on 5th, mem on 6th.
//  4. core rd=0, sel=00, valid -> ready=1, next cycle rf_wr_en=0; mem_wb_valid with ld_outstanding=0 -> granted, wb_err=1.
//  5. After 3 deferrals, flush=1 with core valid -> core_wb_ready=0, defer_cnt=0; next 4 contention cycles mem wins again.
//  6. ld_issue and mem grant in the same cycle with count=1 -> count stays 1; async RST_N low mid-write -> rf_wr_en=0 immediately.

Source files
------------

// File: rtl/rf_wb_scheduler_if.sv
// Write-back request/grant bundle between the core/memory requesters and the RF write-port scheduler.
// The master side drives requests and observes grants; the slave side is the scheduler.
interface rf_wb_scheduler_if #(
  parameter int CNT_W = 2
);
  logic             core_wb_valid;
  logic [1:0]       core_wb_sel;
  logic [4:0]       core_wb_rd;
  logic             core_wb_ready;
  logic             mem_wb_valid;
  logic [4:0]       mem_wb_rd;
  logic             mem_wb_ready;
  logic             ld_issue;
  logic             ld_issue_ok;
  logic             flush;
  logic [1:0]       rf_wr_sel;
  logic             rf_wr_en;
  logic [4:0]       rf_wa;
  logic [CNT_W-1:0] ld_outstanding;
  logic             wb_err;

  modport master (
    output core_wb_valid, core_wb_sel, core_wb_rd,
    output mem_wb_valid, mem_wb_rd, ld_issue, flush,
    input  core_wb_ready, mem_wb_ready, ld_issue_ok,
    input  rf_wr_sel, rf_wr_en, rf_wa, ld_outstanding, wb_err
  );

  modport slave (
    input  core_wb_valid, core_wb_sel, core_wb_rd,
    input  mem_wb_valid, mem_wb_rd, ld_issue, flush,
    output core_wb_ready, mem_wb_ready, ld_issue_ok,
    output rf_wr_sel, rf_wr_en, rf_wa, ld_outstanding, wb_err
  );
endinterface

// File: rtl/rf_wb_scheduler.sv
// Arbitrates the single RF write port between core retire and load return; write issued 1 cycle after grant.
// Requesters are held off via combinational ready; core loses at most MAX_DEFER times in a row before forced priority.
module rf_wb_scheduler #(
  parameter int MAX_DEFER       = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input logic              CLK,
  input logic              RST_N,
  rf_wb_scheduler_if.slave bus
);

  localparam int               DW         = (MAX_DEFER > 1) ? $clog2(MAX_DEFER) : 1;
  localparam logic [DW-1:0]    DEFER_LAST = DW'(MAX_DEFER - 1);
  localparam logic [CNT_W-1:0] OUT_MAX    = CNT_W'(MAX_OUTSTANDING);
  localparam logic [1:0]       SEL_DOUT2  = 2'b10;

  typedef enum logic {
    PRIO_MEM  = 1'b0,
    PRIO_CORE = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DW-1:0]    defer_cnt;
  logic [DW-1:0]    defer_nxt;
  logic [CNT_W-1:0] ld_cnt;
  logic [CNT_W-1:0] ld_cnt_nxt;

  logic core_req;
  logic core_bad;
  logic core_elig;
  logic mem_elig;
  logic core_gnt;
  logic mem_gnt;
  logic ld_ok;
  logic ld_inc;
  logic err_any;

  logic [1:0] wr_sel_q;
  logic       wr_en_q;
  logic [4:0] wr_wa_q;
  logic       err_q;

  always_comb begin
    core_req  = bus.core_wb_valid & ~bus.flush;
    core_bad  = core_req & (bus.core_wb_sel == SEL_DOUT2);
    core_elig = core_req & ~core_bad;
    mem_elig  = bus.mem_wb_valid;
  end

  always_comb begin
    core_gnt = 1'b0;
    mem_gnt  = 1'b0;
    if (state == PRIO_CORE) begin
      core_gnt = core_elig;
      mem_gnt  = mem_elig & ~core_elig;
    end else begin
      mem_gnt  = mem_elig;
      core_gnt = core_elig & ~mem_elig;
    end
  end

  // Fairness FSM: defer_cnt counts consecutive core losses while mem has priority.
  always_comb begin
    state_nxt = state;
    defer_nxt = defer_cnt;
    if (bus.flush) begin
      state_nxt = PRIO_MEM;
      defer_nxt = '0;
    end else begin
      case (state)
        PRIO_MEM: begin
          if (core_elig && mem_gnt) begin
            if (defer_cnt == DEFER_LAST) begin
              state_nxt = PRIO_CORE;
              defer_nxt = '0;
            end else begin
              defer_nxt = defer_cnt + DW'(1);
            end
          end else if (core_gnt) begin
            defer_nxt = '0;
          end
        end
        PRIO_CORE: begin
          if (core_gnt) begin
            state_nxt = PRIO_MEM;
          end
          defer_nxt = '0;
        end
        default: begin
          state_nxt = PRIO_MEM;
          defer_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= PRIO_MEM;
      defer_cnt <= '0;
    end else begin
      state     <= state_nxt;
      defer_cnt <= defer_nxt;
    end
  end

  // A mem grant with nothing outstanding is an underflow: flag it, keep the count at zero.
  always_comb begin
    ld_ok      = (ld_cnt < OUT_MAX);
    ld_inc     = bus.ld_issue & ld_ok;
    ld_cnt_nxt = ld_cnt;
    if (ld_inc && !mem_gnt) begin
      ld_cnt_nxt = ld_cnt + CNT_W'(1);
    end else if (mem_gnt && !ld_inc && (ld_cnt != '0)) begin
      ld_cnt_nxt = ld_cnt - CNT_W'(1);
    end
    err_any = core_bad
            | (bus.ld_issue & ~ld_ok)
            | (mem_gnt & (ld_cnt == '0));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ld_cnt   <= '0;
      err_q    <= 1'b0;
      wr_sel_q <= 2'b00;
      wr_en_q  <= 1'b0;
      wr_wa_q  <= 5'd0;
    end else begin
      ld_cnt <= ld_cnt_nxt;
      err_q  <= err_any;
      if (mem_gnt) begin
        wr_sel_q <= SEL_DOUT2;
        wr_wa_q  <= bus.mem_wb_rd;
        wr_en_q  <= (bus.mem_wb_rd != 5'd0);
      end else if (core_gnt) begin
        wr_sel_q <= bus.core_wb_sel;
        wr_wa_q  <= bus.core_wb_rd;
        wr_en_q  <= (bus.core_wb_rd != 5'd0);
      end else begin
        wr_en_q  <= 1'b0;
      end
    end
  end

  assign bus.core_wb_ready  = core_gnt | core_bad;
  assign bus.mem_wb_ready   = mem_gnt;
  assign bus.ld_issue_ok    = ld_ok;
  assign bus.rf_wr_sel      = wr_sel_q;
  assign bus.rf_wr_en       = wr_en_q;
  assign bus.rf_wa          = wr_wa_q;
  assign bus.ld_outstanding = ld_cnt;
  assign bus.wb_err         = err_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: stimulus pushes expected grants/writes into queues, a negedge monitor checks them.
module tb_rf_wb_scheduler;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;

  rf_wb_scheduler_if #(.CNT_W(2)) bus ();

  rf_wb_scheduler #(
    .MAX_DEFER      (4),
    .MAX_OUTSTANDING(2),
    .CNT_W          (2)
  ) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int   cyc;
    logic crdy;
    logic mrdy;
    logic ok;
  } rrec_t;

  typedef struct {
    int         cyc;
    logic       en;
    logic [1:0] sel;
    logic [4:0] wa;
    logic       err;
    logic [1:0] cnt;
  } wrec_t;

  rrec_t rq[$];
  wrec_t wq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    rrec_t r;
    wrec_t w;
    while (rq.size() > 0 && rq[0].cyc == cyc) begin
      r = rq.pop_front();
      chk("core_wb_ready", {7'd0, bus.core_wb_ready}, {7'd0, r.crdy});
      chk("mem_wb_ready",  {7'd0, bus.mem_wb_ready},  {7'd0, r.mrdy});
      chk("ld_issue_ok",   {7'd0, bus.ld_issue_ok},   {7'd0, r.ok});
    end
    while (wq.size() > 0 && wq[0].cyc == cyc) begin
      w = wq.pop_front();
      chk("rf_wr_en",       {7'd0, bus.rf_wr_en},       {7'd0, w.en});
      chk("rf_wr_sel",      {6'd0, bus.rf_wr_sel},      {6'd0, w.sel});
      chk("rf_wa",          {3'd0, bus.rf_wa},          {3'd0, w.wa});
      chk("wb_err",         {7'd0, bus.wb_err},         {7'd0, w.err});
      chk("ld_outstanding", {6'd0, bus.ld_outstanding}, {6'd0, w.cnt});
    end
  end

  // One cycle of stimulus: readys expected this cycle, registered outputs expected next cycle.
  task automatic step(
    input logic cv, input logic [1:0] cs, input logic [4:0] cr,
    input logic mv, input logic [4:0] mr, input logic li, input logic fl,
    input logic ecr, input logic emr, input logic eok,
    input logic een, input logic [1:0] es, input logic [4:0] ew,
    input logic ee, input logic [1:0] ec);
    @(posedge clk);
    #1;
    bus.core_wb_valid = cv;
    bus.core_wb_sel   = cs;
    bus.core_wb_rd    = cr;
    bus.mem_wb_valid  = mv;
    bus.mem_wb_rd     = mr;
    bus.ld_issue      = li;
    bus.flush         = fl;
    rq.push_back('{cyc: cyc, crdy: ecr, mrdy: emr, ok: eok});
    wq.push_back('{cyc: cyc + 1, en: een, sel: es, wa: ew, err: ee, cnt: ec});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.core_wb_valid = 1'b0;
    bus.core_wb_sel   = 2'b00;
    bus.core_wb_rd    = 5'd0;
    bus.mem_wb_valid  = 1'b0;
    bus.mem_wb_rd     = 5'd0;
    bus.ld_issue      = 1'b0;
    bus.flush         = 1'b0;
    #12;
    chk("rst_rf_wr_en",       {7'd0, bus.rf_wr_en}, 8'd0);
    chk("rst_rf_wr_sel",      {6'd0, bus.rf_wr_sel}, 8'd0);
    chk("rst_rf_wa",          {3'd0, bus.rf_wa}, 8'd0);
    chk("rst_ld_outstanding", {6'd0, bus.ld_outstanding}, 8'd0);
    chk("rst_wb_err",         {7'd0, bus.wb_err}, 8'd0);
    chk("rst_ld_issue_ok",    {7'd0, bus.ld_issue_ok}, 8'd1);
    rst_n = 1'b1;

    //    cv cs     cr  mv mr  li fl  ecr emr eok  een es     ew  ee ec
    // Core ALU write to x5.
    step(1, 2'b11, 5,  0, 0,  0, 0,  1,  0,  1,   1,  2'b11, 5,  0, 0);
    // Fill the outstanding-load window, then overflow it.
    step(0, 2'b00, 0,  0, 0,  1, 0,  0,  0,  1,   0,  2'b11, 5,  0, 1);
    step(0, 2'b00, 0,  0, 0,  1, 0,  0,  0,  1,   0,  2'b11, 5,  0, 2);
    step(0, 2'b00, 0,  0, 0,  1, 0,  0,  0,  0,   0,  2'b11, 5,  1, 2);
    step(0, 2'b00, 0,  0, 0,  0, 0,  0,  0,  0,   0,  2'b11, 5,  0, 2);
    // Continuous contention: mem x4, core, mem.
    step(1, 2'b11, 7,  1, 3,  0, 0,  0,  1,  0,   1,  2'b10, 3,  0, 1);
    step(1, 2'b11, 7,  1, 3,  0, 0,  0,  1,  1,   1,  2'b10, 3,  0, 0);
    step(1, 2'b11, 7,  1, 3,  0, 0,  0,  1,  1,   1,  2'b10, 3,  1, 0);
    step(1, 2'b11, 7,  1, 3,  0, 0,  0,  1,  1,   1,  2'b10, 3,  1, 0);
    step(1, 2'b11, 7,  1, 3,  0, 0,  1,  0,  1,   1,  2'b11, 7,  0, 0);
    step(1, 2'b11, 7,  1, 3,  0, 0,  0,  1,  1,   1,  2'b10, 3,  1, 0);
    // x0 write consumed but suppressed; mem return with nothing outstanding.
    step(1, 2'b00, 0,  0, 0,  0, 0,  1,  0,  1,   0,  2'b00, 0,  0, 0);
    step(0, 2'b00, 0,  1, 9,  0, 0,  0,  1,  1,   1,  2'b10, 9,  1, 0);
    // Illegal core select consumed alongside a mem grant.
    step(1, 2'b10, 4,  1, 6,  0, 0,  1,  1,  1,   1,  2'b10, 6,  1, 0);
    // Three deferrals, flush, then mem wins four more before core.
    step(1, 2'b01, 8,  1, 2,  0, 0,  0,  1,  1,   1,  2'b10, 2,  1, 0);
    step(1, 2'b01, 8,  1, 2,  0, 0,  0,  1,  1,   1,  2'b10, 2,  1, 0);
    step(1, 2'b01, 8,  1, 2,  0, 0,  0,  1,  1,   1,  2'b10, 2,  1, 0);
    step(1, 2'b01, 8,  1, 2,  0, 1,  0,  1,  1,   1,  2'b10, 2,  1, 0);
    step(1, 2'b01, 8,  1, 2,  0, 0,  0,  1,  1,   1,  2'b10, 2,  1, 0);
    step(1, 2'b01, 8,  1, 2,  0, 0,  0,  1,  1,   1,  2'b10, 2,  1, 0);
    step(1, 2'b01, 8,  1, 2,  0, 0,  0,  1,  1,   1,  2'b10, 2,  1, 0);
    step(1, 2'b01, 8,  1, 2,  0, 0,  0,  1,  1,   1,  2'b10, 2,  1, 0);
    step(1, 2'b01, 8,  1, 2,  0, 0,  1,  0,  1,   1,  2'b01, 8,  0, 0);
    step(0, 2'b00, 0,  0, 0,  0, 0,  0,  0,  1,   0,  2'b01, 8,  0, 0);
    // Load issue and return in the same cycle leave the count unchanged.
    step(0, 2'b00, 0,  0, 0,  1, 0,  0,  0,  1,   0,  2'b01, 8,  0, 1);
    step(0, 2'b00, 0,  1, 12, 1, 0,  0,  1,  1,   1,  2'b10, 12, 0, 1);
    step(0, 2'b00, 0,  0, 0,  0, 0,  0,  0,  1,   0,  2'b10, 12, 0, 1);

    // Async reset in the middle of a pending write.
    @(posedge clk);
    #1;
    bus.core_wb_valid = 1'b1;
    bus.core_wb_sel   = 2'b11;
    bus.core_wb_rd    = 5'd5;
    @(posedge clk);
    #1;
    bus.core_wb_valid = 1'b0;
    chk("midwr_rf_wr_en_before", {7'd0, bus.rf_wr_en}, 8'd1);
    chk("midwr_rf_wa_before",    {3'd0, bus.rf_wa}, 8'd5);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_rf_wr_en",       {7'd0, bus.rf_wr_en}, 8'd0);
    chk("midrst_rf_wa",          {3'd0, bus.rf_wa}, 8'd0);
    chk("midrst_rf_wr_sel",      {6'd0, bus.rf_wr_sel}, 8'd0);
    chk("midrst_ld_outstanding", {6'd0, bus.ld_outstanding}, 8'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("queues_drained", 8'(rq.size() + wq.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
